// File: rtl/calc_pkg.sv
// calc_pkg: keycode map, operator and multiplier-state types shared by the calculator core.
package calc_pkg;
    localparam logic [4:0] KEY_STORE = 5'b00001;
    localparam logic [4:0] KEY_CA    = 5'b00010;
    localparam logic [4:0] KEY_CE    = 5'b00011;
    localparam logic [4:0] KEY_EQ    = 5'b00100;
    localparam logic [4:0] KEY_MUL   = 5'b01001;
    localparam logic [4:0] KEY_SUB   = 5'b01010;
    localparam logic [4:0] KEY_ADD   = 5'b01011;
    localparam logic [4:0] KEY_RCL   = 5'b01100;
    localparam int         KEY_DIGIT_BIT = 4;

    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;
    typedef enum logic {IDLE, RUN} mult_state_t;

    function automatic op_t key_to_op(input logic [4:0] k);
        return (k == KEY_ADD) ? OP_ADD : (k == KEY_SUB) ? OP_SUB : (k == KEY_MUL) ? OP_MUL : OP_NONE;
    endfunction
endpackage

// File: rtl/calc_seq_mult.sv
// calc_seq_mult: W-cycle shift-add multiplier; operands latched on start, product valid with done.
module calc_seq_mult
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*W-1:0] o_product
);
    localparam int CW = $clog2(W);

    mult_state_t    r_state;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_a, r_acc, w_acc_nxt;
    logic [W-1:0]   r_b;

    // The final partial product is added combinationally so the result is ready on the last RUN edge.
    assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    assign o_busy    = (r_state == RUN);
    assign o_done    = o_busy && (r_cnt == '0);
    assign o_product = w_acc_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (r_state == IDLE) begin
            if (i_start) begin
                r_state <= RUN;
                r_cnt   <= CW'(W - 1);
                r_a     <= {{W{1'b0}}, i_a};
                r_b     <= i_b;
                r_acc   <= '0;
            end
        end else begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= IDLE;
        end
    end
endmodule

// File: rtl/param_calculator.sv
// param_calculator: hex keypad calculator core with chained operators, entry saturation and overflow flag.
module param_calculator
    import calc_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter bit SEQ_MUL = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                new_key,
    input  logic [4:0]          keycode,
    output logic [4*DIGITS-1:0] x,
    output logic                busy,
    output logic                ovf
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]   r_x, r_y, r_m;
    op_t            r_op;
    logic           r_new_key_q, r_ovf, r_mul_eq;
    op_t            w_key_op;
    logic           w_is_op, w_accept, w_exec, w_start, w_done, w_busy, w_res_ovf;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_res;
    logic [2*W-1:0] w_prod;

    assign w_key_op = key_to_op(keycode);
    assign w_is_op  = (w_key_op != OP_NONE);
    assign w_accept = new_key & ~r_new_key_q & ~w_busy;
    assign w_exec   = w_accept & (r_op != OP_NONE) & (w_is_op | (keycode == KEY_EQ));
    assign w_start  = w_exec & SEQ_MUL & (r_op == OP_MUL);
    assign w_sum    = {1'b0, r_y} + {1'b0, r_x};

    generate
        if (SEQ_MUL) begin : g_seq
            calc_seq_mult #(.W(W)) u_mult (
                .i_clk(clock), .i_rst_n(reset), .i_start(w_start), .i_a(r_y), .i_b(r_x),
                .o_busy(w_busy), .o_done(w_done), .o_product(w_prod)
            );
        end else begin : g_comb
            assign w_busy = 1'b0;
            assign w_done = 1'b0;
            assign w_prod = {{W{1'b0}}, r_y} * {{W{1'b0}}, r_x};
        end
    endgenerate

    always_comb begin
        w_res     = (r_op == OP_ADD) ? w_sum[W-1:0] : (r_op == OP_SUB) ? r_y - r_x : w_prod[W-1:0];
        w_res_ovf = (r_op == OP_ADD) ? w_sum[W] : (r_op == OP_SUB) ? (r_y < r_x) : |w_prod[2*W-1:W];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_m         <= '0;
            r_op        <= OP_NONE;
            r_new_key_q <= 1'b0;
            r_ovf       <= 1'b0;
            r_mul_eq    <= 1'b0;
        end else begin
            r_new_key_q <= new_key;
            // r_mul_eq remembers whether the running multiply feeds X (EQ) or Y (chaining)
            if (w_done) begin
                if (r_mul_eq) r_x <= w_prod[W-1:0];
                else r_y <= w_prod[W-1:0];
                r_ovf <= |w_prod[2*W-1:W];
            end
            if (w_accept) begin
                if (keycode[KEY_DIGIT_BIT]) begin
                    if (r_x[W-1:W-4] == 4'h0) r_x <= {r_x[W-5:0], keycode[3:0]};
                end else if (w_is_op || keycode == KEY_EQ) begin
                    if (w_start) r_mul_eq <= (keycode == KEY_EQ);
                    else if (w_exec) begin
                        r_ovf <= w_res_ovf;
                        if (keycode == KEY_EQ) r_x <= w_res;
                        else r_y <= w_res;
                    end
                    if (keycode == KEY_EQ) r_op <= OP_NONE;
                    else begin
                        if (r_op == OP_NONE) r_y <= r_x;
                        r_x  <= '0;
                        r_op <= w_key_op;
                    end
                end else case (keycode)
                    KEY_STORE: begin
                        r_m <= r_x;
                        r_x <= '0;
                    end
                    KEY_CA: begin
                        r_x   <= '0;
                        r_y   <= '0;
                        r_op  <= OP_NONE;
                        r_ovf <= 1'b0;
                    end
                    KEY_CE:  r_x <= '0;
                    KEY_RCL: r_x <= r_m;
                    default: ;
                endcase
            end
        end
    end

    assign x    = r_x;
    assign busy = w_busy;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_param_calculator.sv
// tb_param_calculator: two calculator instances (4-digit sequential multiply, 6-digit combinational)
// driven with directed and random keys, checked every cycle against a behavioural model.
module tb_param_calculator;
    import calc_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, nk = 1'b0;
    logic [4:0]  kc = '0;
    logic [15:0] x0;
    logic [23:0] x1;
    logic        busy0, busy1, ovf0, ovf1;
    int          checks = 0, failures = 0, bcount = 0;

    // model state, index 0 = DIGITS 4 / SEQ_MUL 1, index 1 = DIGITS 6 / SEQ_MUL 0
    longint unsigned mx[2], my[2], mm[2], mres[2];
    int              mop[2], mb[2];
    bit              mq[2], movf[2], mrovf[2], meq[2];
    int              mw;
    bit              macc, mo;
    longint unsigned mr;

    always #5 clk = ~clk;

    param_calculator #(.DIGITS(4), .SEQ_MUL(1'b1)) dut (
        .clock(clk), .reset(rst_n), .new_key(nk), .keycode(kc), .x(x0), .busy(busy0), .ovf(ovf0)
    );
    param_calculator #(.DIGITS(6), .SEQ_MUL(1'b0)) dut6 (
        .clock(clk), .reset(rst_n), .new_key(nk), .keycode(kc), .x(x1), .busy(busy1), .ovf(ovf1)
    );

    function automatic void arith(input int op, input longint unsigned y, input longint unsigned xv,
                                  input int w, output longint unsigned r, output bit o);
        longint unsigned lim, full;
        lim  = 64'd1 << w;
        full = (op == int'(KEY_ADD)) ? y + xv : (op == int'(KEY_SUB)) ? y - xv : y * xv;
        r    = full % lim;
        o    = (op == int'(KEY_SUB)) ? (y < xv) : (full >= lim);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mx[d] = 0; my[d] = 0; mm[d] = 0; mop[d] = 0; mb[d] = 0;
                mq[d] = 0; movf[d] = 0; meq[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mw   = d ? 24 : 16;
                macc = nk && !mq[d] && mb[d] == 0;
                mq[d] = nk;
                if (mb[d] != 0) begin
                    mb[d]--;
                    if (mb[d] == 0) begin
                        if (meq[d]) mx[d] = mres[d];
                        else my[d] = mres[d];
                        movf[d] = mrovf[d];
                    end
                end
                if (macc) begin
                    if (kc[4]) begin
                        if ((mx[d] >> (mw - 4)) == 0) mx[d] = (mx[d] << 4) | kc[3:0];
                    end else if (kc == KEY_STORE) begin
                        mm[d] = mx[d]; mx[d] = 0;
                    end else if (kc == KEY_CA) begin
                        mx[d] = 0; my[d] = 0; mop[d] = 0; movf[d] = 0;
                    end else if (kc == KEY_CE) mx[d] = 0;
                    else if (kc == KEY_RCL) mx[d] = mm[d];
                    else if (kc inside {KEY_EQ, KEY_ADD, KEY_SUB, KEY_MUL}) begin
                        if (mop[d] != 0) begin
                            arith(mop[d], my[d], mx[d], mw, mr, mo);
                            if (mop[d] == int'(KEY_MUL) && d == 0) begin
                                mb[d] = 16; mres[d] = mr; mrovf[d] = mo; meq[d] = (kc == KEY_EQ);
                            end else if (kc == KEY_EQ) begin
                                mx[d] = mr; movf[d] = mo;
                            end else begin
                                my[d] = mr; movf[d] = mo;
                            end
                        end else if (kc != KEY_EQ) my[d] = mx[d];
                        if (kc == KEY_EQ) mop[d] = 0;
                        else begin
                            mx[d] = 0; mop[d] = int'(kc);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            chk("x0", x0, mx[0]);
            chk("busy0", busy0, mb[0] != 0);
            chk("ovf0", ovf0, movf[0]);
            chk("x1", x1, mx[1]);
            chk("busy1", busy1, 0);
            chk("ovf1", ovf1, movf[1]);
            if (busy0) bcount++;
        end
    endtask

    task automatic press(input logic [4:0] code, input int hold = 1);
        nk = 1'b1;
        kc = code;
        repeat (hold) tick();
        nk = 1'b0;
        tick();
    endtask

    task automatic num(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) press({1'b1, v[4*i +: 4]});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy0; i++) tick();
        chk("idle_timeout", busy0, 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_x0", x0, 0); chk("rst_busy0", busy0, 0); chk("rst_ovf0", ovf0, 0); chk("rst_x1", x1, 0);
        rst_n = 1'b1;
        tick();
        // scenario 1
        num(32'h1234, 4); press(KEY_ADD); chk("s1_add", x0, 16'h0000);
        num(32'h5678, 4); chk("s1_entry", x0, 16'h5678);
        press(KEY_EQ); chk("s1_eq", x0, 16'h68AC); chk("s1_ovf", ovf0, 0); chk("s1_eq6", x1, 24'h0068AC);
        // scenario 2
        press(KEY_SUB); num(32'h5678, 4); press(KEY_EQ); chk("s2_sub", x0, 16'h1234);
        press(KEY_MUL); num(32'h3, 1); press(KEY_CE); num(32'h2, 1);
        bcount = 0;
        press(KEY_EQ);
        press(5'b11001);
        wait_idle();
        chk("s2_busy_cycles", bcount, 16); chk("s2_mul", x0, 16'h2468);
        // scenario 3
        press(KEY_STORE); chk("s3_store", x0, 0);
        press(KEY_RCL); chk("s3_rcl", x0, 16'h2468);
        press(KEY_CA); chk("s3_ca", x0, 0);
        press(KEY_RCL); chk("s3_rcl_after_ca", x0, 16'h2468);
        // scenario 4
        press(KEY_CA); num(32'hFFFF, 4); press(KEY_ADD); num(32'h2, 1); press(KEY_EQ);
        chk("s4_add", x0, 16'h0001); chk("s4_add_ovf", ovf0, 1);
        press(KEY_CA); num(32'h1, 1); press(KEY_SUB); num(32'h2, 1); press(KEY_EQ);
        chk("s4_sub", x0, 16'hFFFF); chk("s4_sub_ovf", ovf0, 1);
        press(KEY_CA); num(32'h1000, 4); press(KEY_MUL); num(32'h10, 2); press(KEY_EQ); wait_idle();
        chk("s4_mul", x0, 16'h0000); chk("s4_mul_ovf", ovf0, 1);
        press(KEY_CA); chk("s4_ca_ovf", ovf0, 0);
        // scenario 5
        num(32'h12345, 5); chk("s5_sat", x0, 16'h1234);
        press(KEY_CA); press(5'b10111, 3); chk("s5_hold", x0, 16'h0007);
        press(KEY_CA); num(32'h1, 1); press(KEY_ADD); num(32'h2, 1); press(KEY_ADD); num(32'h4, 1); press(KEY_EQ);
        chk("s5_chain", x0, 16'h0007);
        press(KEY_CA); num(32'h3, 1); press(KEY_MUL); num(32'h3, 1);
        bcount = 0;
        press(KEY_ADD); wait_idle();
        chk("s5_chain_mul_cycles", bcount, 16);
        num(32'h1, 1); press(KEY_EQ); chk("s5_chain_mul", x0, 16'h000A);
        // scenario 6: reset in the fifth RUN cycle
        press(KEY_CA); num(32'h2, 1); press(KEY_MUL); num(32'h3, 1);
        nk = 1'b1; kc = KEY_EQ; tick(); nk = 1'b0;
        repeat (4) tick();
        chk("s6_busy_before", busy0, 1); chk("s6_x_before", x0, 16'h0003);
        #2 rst_n = 1'b0;
        #1 chk("s6_rst_x", x0, 0); chk("s6_rst_busy", busy0, 0); chk("s6_rst_ovf", ovf0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        num(32'h5, 1); press(KEY_ADD); num(32'h1, 1); press(KEY_EQ);
        chk("s6_after", x0, 16'h0006); chk("s6_after6", x1, 24'h000006);
        press(KEY_CA); num(32'h1234, 4); press(KEY_ADD); num(32'h5678, 4); press(KEY_EQ);
        chk("s6_rep", x0, 16'h68AC); chk("s6_rep6", x1, 24'h0068AC);
        // random phase
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [4:0] code;
            r = $urandom_range(0, 99);
            if (r < 55) code = {1'b1, 4'($urandom_range(0, 15))};
            else if (r < 85) begin
                case ($urandom_range(0, 3))
                    0: code = KEY_ADD;
                    1: code = KEY_SUB;
                    2: code = KEY_MUL;
                    default: code = KEY_EQ;
                endcase
            end else if (r < 92) begin
                case ($urandom_range(0, 2))
                    0: code = KEY_STORE;
                    1: code = KEY_RCL;
                    default: code = KEY_CE;
                endcase
            end else if (r < 95) code = KEY_CA;
            else code = 5'($urandom_range(0, 31));
            press(code, $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/param_calculator.md
Name: param_calculator

Overview:
- Next-generation keypad calculator core with a parametrised digit count.
- Sequential shift-add multiplier with a busy handshake.
- Chained operators, entry saturation and an overflow flag.
- Sits between the keypad scanner (new_key/keycode) and the hex display driver (x). The keycode map is the existing 5-bit calculator map.

Parameters:
DIGITS, 4, number of hex digits; datapath width W = 4*DIGITS (localparam). Legal range 2..8.
SEQ_MUL, 1, 1 = W-cycle shift-add multiplier; 0 = single-cycle combinational multiply.

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
new_key  input  1  key strobe from scanner, level; may stay high more than one cycle
keycode  input  5  key code, valid while new_key high
x  output  W  display register (X)
busy  output  1  high while a multiply is in progress
ovf  output  1  sticky overflow/borrow flag for the last completed operation

Behaviour:
- Reset (reset=0, asynchronous): X, Y (accumulator), M (memory), pending op, multiplier state, new_key_q, ovf, busy all 0.
- Key acceptance: the key is accepted at the rising edge where new_key=1, new_key_q=0 and busy=0.
  - new_key held high for several cycles gives exactly one acceptance.
  - A rising strobe while busy=1 is dropped, not queued.
- Keycodes:
  - 1_dddd: digit d (0..F).
  - 00001: STORE. 00010: CA. 00011: CE. 00100: EQ.
  - 01001: MUL. 01010: SUB. 01011: ADD. 01100: RCL.
  - All others: ignored, no state change.
- Digit: if X[W-1:W-4]==0, X <= {X[W-5:0],d}. Otherwise the digit is ignored (entry saturation, no wrap).
- Operator (ADD/SUB/MUL):
  - No op pending: Y <= X, X <= 0, op <= key.
  - Op pending (chaining): execute Y op X into Y, then X <= 0, op <= new key.
- EQ:
  - Op pending: X <= Y op X, op <= none.
  - No op pending: no change.
- CE: X <= 0. CA: X, Y, op, ovf <= 0; M retained.
- STORE: M <= X, X <= 0. RCL: X <= M.
- Arithmetic is unsigned, modulo 2^W:
  - ADD: ovf = carry out.
  - SUB: ovf = borrow (Y < X).
  - MUL: ovf = product[2W-1:W] != 0.
  - ovf updates only when an arithmetic op completes; CA and reset clear it.
- Latency:
  - Digit, CE, CA, STORE, RCL, ADD/SUB execution: result in X at the accepting edge, visible the next cycle.
  - MUL execution with SEQ_MUL=1: busy rises at the accepting edge and stays high exactly W cycles. The result is written (X for EQ, Y for chaining) at the edge where busy falls.
- Multiplier FSM states: IDLE -> RUN (counter W-1..0, shift-add one multiplier bit per cycle) -> IDLE on count 0. Operands are latched at the accepting edge; later input changes do not affect the result.
- Reset mid-multiply: immediate abort, all registers 0, busy=0.
- CA cannot interrupt a multiply: it is dropped like any key while busy.

Decomposition:
- calc_pkg:
  - keycode localparams (KEY_STORE, KEY_CA, KEY_CE, KEY_EQ, KEY_MUL, KEY_SUB, KEY_ADD, KEY_RCL, digit prefix bit).
  - op enum (OP_NONE, OP_ADD, OP_SUB, OP_MUL).
  - FSM state enum (IDLE, RUN).
- Sub-module calc_seq_mult (parameter W):
  - Inputs: start, a, b.
  - Outputs: busy, done pulse, product[2W-1:0].
  - Used only when SEQ_MUL=1.
- The top level holds the key edge detector, command decode, X/Y/M registers and the ADD/SUB unit.

Test Plan:
1. DIGITS=4: keys 1,2,3,4,ADD,5,6,7,8,EQ -> x=0000 after ADD, x=5678 before EQ, x=68AC after EQ, ovf=0.
2. Continue: SUB,5,6,7,8,EQ -> x=1234, ovf=0. Then MUL,3,CE,2,EQ -> busy high exactly 16 cycles, x=2468 on busy fall. A digit strobe during busy is dropped, x=2468.
3. STORE -> x=0000; RCL -> x=2468; CA -> x=0000; RCL -> x=2468 (M kept across CA).
4. Overflow cases, each starting from CA:
   - F,F,F,F,ADD,2,EQ -> x=0001, ovf=1.
   - 1,SUB,2,EQ -> x=FFFF, ovf=1.
   - 1,0,0,0,MUL,1,0,EQ -> x=0000, ovf=1.
   - CA -> ovf=0.
5. Entry and chaining:
   - 1,2,3,4,5 -> x=1234.
   - new_key held high 3 cycles with digit 7 after CA -> x=0007.
   - 1,ADD,2,ADD,4,EQ -> x=0007.
   - 3,MUL,3,ADD (chained MUL, busy 16 cycles), 1,EQ -> x=000A.
6. Reset: assert reset mid-multiply (cycle 5 of RUN) -> x=0, busy=0, ovf=0 immediately without a clock edge. Then 5,ADD,1,EQ -> x=0006. Repeat scenario 1 with DIGITS=6, SEQ_MUL=0 -> x=0068AC, busy never high.
